amm_ram_slave: RTL and testbench
================================

# amm_ram_slave

Synthesizable single-clock Avalon-MM slave RAM with byte enables, fixed pipelined read latency and optional incrementing bursts. It sits directly downstream of `amm_cdc` in the slave clock domain and serves as the on-chip memory target for the CDC's slave-side interface. It replaces the behavioural `amm_memory` model wherever real RTL is required.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; depth is 2**ADDR_W words.
- `DATA_W`, 64: data width; must be a multiple of 8.
- `BURST_W`, 2: burstcount width; maximum burst is 2**(BURST_W-1) words.
- `READ_LATENCY`, 2: cycles from read issue to `readdatavalid`; legal range 1..4.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `amm_address_i` in ADDR_W: word address.
- `amm_read_i` in 1: read request.
- `amm_write_i` in 1: write request.
- `amm_writedata_i` in DATA_W: write data.
- `amm_byteenable_i` in DATA_W/8: per-byte write enable; bit n covers byte n.
- `amm_burstcount_i` in BURST_W: burst length in words.
- `amm_waitrequest_o` out 1: stall; a command is accepted only when the request is high and this output is low.
- `amm_readdata_o` out DATA_W: read data.
- `amm_readdatavalid_o` out 1: qualifies `amm_readdata_o`.

## Operation
- The memory array is not reset; its contents are undefined after power-up.
- FSM states:
  - IDLE (`waitrequest`=0).
  - WR_BURST (`waitrequest`=0).
  - RD_BURST (`waitrequest`=1).
- IDLE, write accepted:
  - The word at `amm_address_i` is written, bytes gated by `byteenable`.
  - If burstcount > 1: latch next address = addr+1 and remaining = burstcount-1, then go to WR_BURST.
- WR_BURST:
  - Each accepted write beat uses the internal address; `amm_address_i` and `amm_burstcount_i` are ignored.
  - Each beat increments the address and decrements remaining.
  - Return to IDLE in the cycle after the beat that brings remaining to 0.
  - Idle cycles (`write`=0) do not advance the burst.
  - `amm_read_i` is ignored.
- IDLE, read accepted:
  - Issue a read of `amm_address_i`.
  - If burstcount > 1: go to RD_BURST and issue one further read per cycle at addr+1 … addr+burstcount-1, then return to IDLE after the last issue.
- burstcount = 0 is treated as 1.
- Simultaneous `read` and `write` in IDLE: the write wins and the read is dropped. This is illegal stimulus; the bench asserts it never occurs.
- Address arithmetic is modulo 2**ADDR_W: 2**ADDR_W-1 wraps to 0.
- Read ordering: read data reflects the array at the issue edge. A write accepted in any later cycle does not alter data already in the read pipeline.

## Timing
- Reset values:
  - `amm_waitrequest_o`=1 while `rst_i` is high and 0 from the first cycle after deassertion.
  - `amm_readdatavalid_o`=0.
  - `amm_readdata_o`=0.
  - FSM=IDLE, burst counters=0, read pipeline valids cleared.
- Reset asserted mid-burst: the burst is abandoned. No `readdatavalid` is produced after the reset edge for reads issued before it.
- Write: the array is updated at the acceptance edge. A read issued in the next cycle returns the new data.
- Read: a read issued at edge N produces `readdatavalid`=1 with data at edge N+READ_LATENCY, for exactly one cycle per word.
  - Burst words return on consecutive cycles in address order.
- Back-to-back single reads in IDLE: one per cycle with no stall, so throughput is 1 word/cycle.
- RD_BURST of length B holds `waitrequest` high for B-1 cycles after acceptance.
- `amm_readdata_o` holds its last value when `readdatavalid`=0.

## Configuration
- `AMM_RAM_SLAVE_BURST_EN` defined:
  - Burst logic is compiled in as described above.
- `AMM_RAM_SLAVE_BURST_EN` undefined:
  - `amm_burstcount_i` is present but ignored, and every access is single-word.
  - The FSM reduces to IDLE, so `waitrequest` is 0 at all times after reset.
  - Only the read pipeline and array remain.

## Test plan
- Reset, then write addr 0x10 data 0x0123456789ABCDEF with be=0xFF, then read 0x10 -> `readdatavalid` exactly READ_LATENCY cycles after the read is accepted, data 0x0123456789ABCDEF.
- Partial write to 0x10 with be=0x0F and data 0xFFFFFFFFFFFFFFFF, then read -> 0x01234567FFFFFFFF.
- Burst write at 0xFF, burstcount=2, data A then B; then burst read at 0xFF, burstcount=2 -> A then B on consecutive cycles, proving the 0xFF->0x00 wrap. Check `waitrequest`=1 for exactly 1 cycle after the read is accepted.
- Read 0x20 (old value X), write 0x20 with Y in the next cycle -> the read returns X. A second read issued after the write returns Y.
- Burst read with burstcount=2 in progress, assert `rst_i` for 1 cycle -> no `readdatavalid` after reset, and `waitrequest` is 0 one cycle after `rst_i` falls.
- Build without `AMM_RAM_SLAVE_BURST_EN`: read with burstcount=2 -> exactly one `readdatavalid`, and `waitrequest` is never asserted after reset.

Source files
------------

// File: rtl/amm_ram_slave.sv
// rtl/amm_ram_slave.sv - Avalon-MM slave RAM with byte enables, fixed read latency and optional bursts
// Incrementing bursts are compiled in only when AMM_RAM_SLAVE_BURST_EN is defined.
module amm_ram_slave #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 64,
  parameter int BURST_W      = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   amm_address_i,
  input  logic                amm_read_i,
  input  logic                amm_write_i,
  input  logic [DATA_W-1:0]   amm_writedata_i,
  input  logic [DATA_W/8-1:0] amm_byteenable_i,
  input  logic [BURST_W-1:0]  amm_burstcount_i,
  output logic                amm_waitrequest_o,
  output logic [DATA_W-1:0]   amm_readdata_o,
  output logic                amm_readdatavalid_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_acc;
  logic              w_rd_issue;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

`ifdef AMM_RAM_SLAVE_BURST_EN
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_BURST = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [BURST_W-1:0] r_remain;
  logic [BURST_W-1:0] w_remain_nxt;
  logic [BURST_W-1:0] w_bc_eff;
  logic               w_burst_req;
  logic               w_rd_acc;

  // A zero burstcount is a single-word access.
  assign w_bc_eff    = (amm_burstcount_i == '0) ? BURST_W'(1) : amm_burstcount_i;
  assign w_burst_req = (w_bc_eff > BURST_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_remain_nxt = r_remain;
    case (r_state)
      S_IDLE: begin
        if ((w_wr_acc || w_rd_acc) && w_burst_req) begin
          w_state_nxt  = w_wr_acc ? S_WR_BURST : S_RD_BURST;
          w_addr_nxt   = amm_address_i + ADDR_W'(1);
          w_remain_nxt = w_bc_eff - BURST_W'(1);
        end
      end
      S_WR_BURST: begin
        if (w_wr_acc) begin
          w_addr_nxt   = r_addr + ADDR_W'(1);
          w_remain_nxt = r_remain - BURST_W'(1);
          if (r_remain == BURST_W'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RD_BURST: begin
        w_addr_nxt   = r_addr + ADDR_W'(1);
        w_remain_nxt = r_remain - BURST_W'(1);
        if (r_remain == BURST_W'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reads inside a burst are self-issued from the internal address, one per cycle.
  always_comb begin
    amm_waitrequest_o = rst_i || (r_state == S_RD_BURST);
    w_wr_acc   = amm_write_i && !amm_waitrequest_o;
    w_rd_acc   = amm_read_i && !amm_write_i && !amm_waitrequest_o && (r_state == S_IDLE);
    w_rd_issue = w_rd_acc || (r_state == S_RD_BURST);
    w_wr_addr  = (r_state == S_WR_BURST) ? r_addr : amm_address_i;
    w_rd_addr  = (r_state == S_RD_BURST) ? r_addr : amm_address_i;
  end
`else
  logic w_unused_burstcount;

  assign w_unused_burstcount = ^amm_burstcount_i;

  always_comb begin
    amm_waitrequest_o = rst_i;
    w_wr_acc   = amm_write_i && !rst_i;
    w_rd_issue = amm_read_i && !amm_write_i && !rst_i;
    w_wr_addr  = amm_address_i;
    w_rd_addr  = amm_address_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (amm_byteenable_i[b]) begin
          r_mem[w_wr_addr][b*8 +: 8] <= amm_writedata_i[b*8 +: 8];
        end
      end
    end
  end

  // Data is captured at issue, so later writes never disturb words already in flight.
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [DATA_W-1:0]       r_pipe_dat [READ_LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_pipe_dat[k] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_issue;
      if (w_rd_issue) begin
        r_pipe_dat[0] <= r_mem[w_rd_addr];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) begin
          r_pipe_dat[k] <= r_pipe_dat[k-1];
        end
      end
    end
  end

  assign amm_readdatavalid_o = r_pipe_vld[READ_LATENCY-1];
  assign amm_readdata_o      = r_pipe_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_amm_ram_slave.sv
// tb/tb_amm_ram_slave.sv - self-checking bench for amm_ram_slave against a transaction-level model
`timescale 1ns/1ps
module tb_amm_ram_slave;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 2;
  localparam int RL      = 2;
  localparam int NB      = DATA_W / 8;
  localparam int DEPTH   = 1 << ADDR_W;
`ifdef AMM_RAM_SLAVE_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic               clk   = 1'b0;
  logic               rst   = 1'b1;
  logic [ADDR_W-1:0]  addr  = '0;
  logic               rd    = 1'b0;
  logic               wr    = 1'b0;
  logic [DATA_W-1:0]  wdata = '0;
  logic [NB-1:0]      be    = '0;
  logic [BURST_W-1:0] bc    = '0;
  logic               waitreq;
  logic               rvalid;
  logic [DATA_W-1:0]  rdata;

  always #5 clk = ~clk;

  amm_ram_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .READ_LATENCY(RL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .amm_address_i(addr), .amm_read_i(rd), .amm_write_i(wr),
    .amm_writedata_i(wdata), .amm_byteenable_i(be), .amm_burstcount_i(bc),
    .amm_waitrequest_o(waitreq), .amm_readdata_o(rdata), .amm_readdatavalid_o(rvalid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: memory image plus a queue of reads with their due cycles.
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;
  logic [DATA_W-1:0] m_mem [DEPTH];
  rd_t               exp_q [$];
  int                rd_busy = 0;
  int                wr_left = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] last_data = '0;
  logic [DATA_W-1:0] obs_q [$];
  int                obs_cyc [$];
  int                wait_after_rst = 0;

  function automatic int beats(input logic [BURST_W-1:0] b);
    if (!BURST_EN || b == '0) return 1;
    return int'(b);
  endfunction

  always @(posedge clk) begin
    logic [ADDR_W-1:0] a;
    int n;
    cyc = cyc + 1;
    if (rst) begin
      check_en = 1'b1;
      exp_q.delete();
      rd_busy = 0;
      wr_left = 0;
      last_data = '0;
    end else begin
      assert (!(rd && wr));
      if (rd_busy > 0) begin
        rd_busy--;
      end else if (wr) begin
        if (wr_left > 0) begin
          a = wr_addr;
          wr_addr = wr_addr + 1'b1;
          wr_left--;
        end else begin
          a = addr;
          n = beats(bc);
          if (n > 1) begin
            wr_left = n - 1;
            wr_addr = addr + 1'b1;
          end
        end
        for (int k = 0; k < NB; k++) if (be[k]) m_mem[a][k*8 +: 8] = wdata[k*8 +: 8];
      end else if (rd && wr_left == 0) begin
        n = beats(bc);
        for (int i = 0; i < n; i++) begin
          a = addr + ADDR_W'(i);
          exp_q.push_back('{cyc + RL - 1 + i, m_mem[a]});
        end
        rd_busy = n - 1;
      end
    end
  end

  always @(negedge clk) begin
    rd_t e;
    bit exp_vld;
    if (check_en) begin
      chk("waitrequest", DATA_W'(waitreq), DATA_W'(rst || rd_busy > 0));
      if (waitreq === 1'b1 && !rst) wait_after_rst++;
      exp_vld = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("readdatavalid", DATA_W'(rvalid), DATA_W'(exp_vld));
      if (exp_vld) begin
        e = exp_q.pop_front();
        last_data = e.data;
      end
      chk("readdata", rdata, last_data);
      if (rvalid === 1'b1) begin
        obs_q.push_back(rdata);
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input bit is_wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [NB-1:0] b, input logic [BURST_W-1:0] n, output int acc);
    logic w;
    int tries;
    tries = 0;
    acc = -1;
    addr = a; wdata = d; be = b; bc = n; wr = is_wr; rd = !is_wr;
    while (acc < 0 && tries < 20) begin
      @(negedge clk);
      w = waitreq;
      step();
      if (w === 1'b0) acc = cyc;
      tries++;
    end
    rd = 1'b0;
    wr = 1'b0;
    chk("cmd_accept_timeout", DATA_W'(acc < 0), 64'd0);
  endtask

  task automatic wait_obs(input int n, input string name);
    for (int i = 0; i < 20 && obs_q.size() < n; i++) step();
    chk(name, DATA_W'(obs_q.size()), DATA_W'(n));
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    int acc0;
    int acc1;
    int op;
    logic [DATA_W-1:0] va;
    logic [DATA_W-1:0] vb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_waitrequest", DATA_W'(waitreq), 64'd1);
    chk("reset_readdatavalid", DATA_W'(rvalid), 64'd0);
    chk("reset_readdata", rdata, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("waitrequest_after_reset", DATA_W'(waitreq), 64'd0);
    step();

    for (int i = 0; i < DEPTH; i++) cmd(1'b1, ADDR_W'(i), {$urandom, $urandom}, '1, 2'd1, acc0);

    clear_obs();
    cmd(1'b1, 8'h10, 64'h0123456789ABCDEF, 8'hFF, 2'd1, acc0);
    cmd(1'b0, 8'h10, '0, '0, 2'd1, acc0);
    wait_obs(1, "a_count");
    if (obs_q.size() > 0) begin
      chk("a_data", obs_q[0], 64'h0123456789ABCDEF);
      chk("a_latency", DATA_W'(obs_cyc[0] + 1 - acc0), DATA_W'(RL));
    end

    clear_obs();
    cmd(1'b1, 8'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 2'd1, acc0);
    cmd(1'b0, 8'h10, '0, '0, 2'd1, acc0);
    wait_obs(1, "b_count");
    if (obs_q.size() > 0) chk("b_data", obs_q[0], 64'h01234567FFFFFFFF);
    chk("b_model_mem", m_mem[16], 64'h01234567FFFFFFFF);

`ifdef AMM_RAM_SLAVE_BURST_EN
    va = 64'hA5A5_0000_1111_2222;
    vb = 64'h5A5A_3333_4444_5555;
    cmd(1'b1, 8'hFF, va, '1, 2'd2, acc0);
    cmd(1'b1, 8'h33, vb, '1, 2'd0, acc1);
    clear_obs();
    cmd(1'b0, 8'hFF, '0, '0, 2'd2, acc0);
    @(negedge clk);
    chk("c_wait_high", DATA_W'(waitreq), 64'd1);
    step();
    @(negedge clk);
    chk("c_wait_low", DATA_W'(waitreq), 64'd0);
    step();
    wait_obs(2, "c_count");
    if (obs_q.size() > 1) begin
      chk("c_first", obs_q[0], va);
      chk("c_second_wrapped", obs_q[1], vb);
      chk("c_consecutive", DATA_W'(obs_cyc[1] - obs_cyc[0]), 64'd1);
    end
    chk("c_model_wrap", m_mem[0], vb);
`else
    clear_obs();
    cmd(1'b0, 8'h10, '0, '0, 2'd2, acc0);
    repeat (RL + 6) step();
    chk("nb_single_valid", DATA_W'(obs_q.size()), 64'd1);
`endif

    va = 64'h1111_2222_3333_4444;
    vb = 64'hAAAA_BBBB_CCCC_DDDD;
    cmd(1'b1, 8'h20, va, '1, 2'd1, acc0);
    clear_obs();
    cmd(1'b0, 8'h20, '0, '0, 2'd1, acc0);
    cmd(1'b1, 8'h20, vb, '1, 2'd1, acc0);
    cmd(1'b0, 8'h20, '0, '0, 2'd1, acc0);
    wait_obs(2, "d_count");
    if (obs_q.size() > 1) begin
      chk("d_old_value", obs_q[0], va);
      chk("d_new_value", obs_q[1], vb);
    end

    cmd(1'b0, 8'h40, '0, '0, 2'd2, acc0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_obs();
    @(negedge clk);
    chk("e_wait_after_rst", DATA_W'(waitreq), 64'd0);
    repeat (8) step();
    chk("e_no_valid_after_rst", DATA_W'(obs_q.size()), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      op    = $urandom_range(0, 9);
      addr  = ADDR_W'($urandom);
      wdata = {$urandom, $urandom};
      be    = NB'($urandom);
      bc    = BURST_W'($urandom_range(0, 2));
      rd    = (op < 4);
      wr    = (op >= 4 && op < 8);
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    rd = 1'b0;
    wr = 1'b0;
    rst = 1'b0;
    repeat (RL + 6) step();
    chk("drain", DATA_W'(exp_q.size()), 64'd0);

`ifndef AMM_RAM_SLAVE_BURST_EN
    chk("nb_wait_never", DATA_W'(wait_after_rst), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
